v_pipe_update: RTL and testbench
================================

// Module: v_pipe_update
// PURPOSE
//  - Write-side counterpart of the list query pipeline: read-modify-write of the per-product state table.
//  - Each accepted command is read in S0, captured in S1, modified in S2, written in S3 and answered in S4.
//  - Exports per-stage valid/prod_id (S1..S4) so the query pipeline can flag in-flight IDs as busy.
// PARAMETERS
//  - ENTRIES_N  default v_pkg::ENTRIES_N  levels per product list; width of the vld/key/volume vectors.
// PORTS
//  - clk              in   1                   clock
//  - rst              in   1                   reset; synchronous, active-high
//  - i_upd_vld        in   1                   command valid
//  - i_upd_op         in   2                   opcode: 0 ADD, 1 DEL, 2 REP, 3 CLR
//  - i_upd_prod_id    in   id_t                product ID (state table address)
//  - i_upd_level      in   level_t             target level
//  - i_upd_key        in   key_t               key (ADD/REP)
//  - i_upd_size       in   volume_t            volume (ADD/REP)
//  - o_upd_rdy        out  1                   command accepted when i_upd_vld & o_upd_rdy
//  - o_upd_vld_r      out  1                   response valid (S4)
//  - o_upd_error      out  1                   response error (S4)
//  - o_state_ren      out  1                   state table read enable
//  - o_state_raddr    out  addr_t              state table read address
//  - i_state_rdata    in   state_t             read data; 1-cycle latency (valid in S1)
//  - o_state_wen      out  1                   state table write enable (registered, S3)
//  - o_state_waddr    out  addr_t              write address
//  - o_state_wdata    out  state_t             write data
//  - o_sN_upd_vld_r   out  1     (N=1..4)      stage N occupied
//  - o_sN_upd_prod_id_r out id_t (N=1..4)      stage N product ID
// BEHAVIOUR
//  - Reset: all stage valids 0; o_upd_vld_r, o_upd_error, o_state_wen, o_state_ren = 0; o_upd_rdy = 1.
//  - Reset does not clear the state table.
//  - Reset mid-operation discards in-flight commands: no write, no response.
//  - S0: o_state_ren = i_upd_vld & o_upd_rdy; o_state_raddr = i_upd_prod_id (combinational).
//  - S0: a command is accepted only when i_upd_vld & o_upd_rdy.
//  - S1: i_state_rdata is captured into S2 together with the command.
//  - S2 compute, on captured state st and decoded level L:
//    - ADD: error if L >= ENTRIES_N or st.vld[L]. Otherwise set vld[L], key[L], volume[L]; listsize+1.
//    - DEL: error if L >= ENTRIES_N or !st.vld[L]. Otherwise clear vld[L]; listsize-1.
//    - REP: error if L >= ENTRIES_N or !st.vld[L]. Otherwise overwrite key[L] and volume[L]; listsize unchanged.
//    - CLR: never errors; vld = '0, listsize = 0; key/volume left as is.
//    - Listsize arithmetic: within listsize_t. Never wraps, because ADD/DEL errors guard both bounds.
//  - S3: o_state_wen = S3 valid & !S3 error; waddr = S3 prod_id; wdata = S3 next state.
//    - Write lands at the end of S3.
//  - S4: o_upd_vld_r = 1 for exactly one cycle per accepted command; o_upd_error = S4 error.
//    - o_upd_error is 0 whenever o_upd_vld_r = 0.
//  - Errored commands still occupy S1..S4 and are still exported as busy.
//  - Latency: accept at cycle T -> response at T+4. Throughput: one command per cycle when o_upd_rdy = 1.
//  - Same-ID hazard (no forwarding):
//    - o_upd_rdy = !(any Sk valid with prod_id == i_upd_prod_id, k = 1..3).
//    - S4 does not stall: its write has already landed, so a read issued then returns the new state.
//  - Different IDs never stall.
// CONFIGURATION
//  - V_PIPE_UPDATE_FWD_EN defined: o_upd_rdy is tied to 1 (still 0 during reset).
//    - Source of st at S1->S2 capture, youngest older match first: S2 next state, S3 wdata, S4 wdata, else i_state_rdata.
//    - S4 wdata is forwarded because a read issued in the same cycle as the older command's write (S3) is undefined.
//    - Forwarding uses the S3/S4 next state even when that command errored, since an errored command leaves st unchanged.
//  - V_PIPE_UPDATE_FWD_EN undefined: the stall rule above applies; no forwarding muxes are built.
// TESTING
//  - Reset: rst=1 for 2 cycles with i_upd_vld=1 -> no ren, wen, or response; o_upd_rdy=1 after reset.
//  - ADD L=2 key=0x5 size=0x10 to empty id 3 -> wen at T+3 with vld[2]=1, listsize=1; response T+4, error=0.
//  - ADD again id 3 L=2 -> o_upd_error=1, no wen, listsize stays 1.
//  - DEL id 3 L=1 (invalid) -> error=1, no wen.
//  - Back-to-back ADD L0, ADD L1 to id 7, no FWD:
//    - o_upd_rdy=0 for 3 cycles; second write has vld=0b011, listsize=2.
//  - Same sequence with FWD: o_upd_rdy stays 1; responses at T+4 and T+5; final vld=0b011, listsize=2.
//  - CLR id 7 while an ADD to id 9 is in flight -> id 7 vld=0, listsize=0; id 9 unaffected.
//  - o_s1..s4_upd_vld_r/prod_id_r track the command each cycle.

Source files
------------

// File: rtl/v_pipe_update.sv
// v_pipe_update: write-side read-modify-write pipeline for the per-product state table.
//
// A command accepted in S0 issues a table read, captures the read data in S1,
// computes the updated list state in S2, writes it in S3 and responds in S4.
// Per-stage valid/prod_id (S1..S4) are exported so the query pipeline can mark
// in-flight products as busy.
//
// Optional feature macro: V_PIPE_UPDATE_FWD_EN
//   undefined : same-ID commands stall while an older one sits in S1..S3.
//   defined   : o_upd_rdy is held high (low only in reset) and the S1->S2
//               capture forwards the newest in-flight state for that ID.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_upd_vld/op/prod_id/level/key/size, o_upd_rdy   command input
//   o_upd_vld_r, o_upd_error    response (S4)
//   o_state_ren/raddr, i_state_rdata                  table read, 1-cycle latency
//   o_state_wen/waddr/wdata     table write (S3)
//   o_sN_upd_vld_r, o_sN_upd_prod_id_r (N=1..4)       stage occupancy export
//
// Handshake: a command transfers on a rising edge where i_upd_vld & o_upd_rdy
// are both high and rst is low; o_upd_rdy does not depend on i_upd_vld, the
// command fields must be held stable while i_upd_vld is high and not accepted.

package v_pkg;
    localparam int ENTRIES_N = 4;
    localparam int ID_W      = 4;

    typedef logic [ID_W-1:0]                    id_t;
    typedef id_t                                addr_t;
    typedef logic [2:0]                         level_t;
    typedef logic [7:0]                         key_t;
    typedef logic [15:0]                        volume_t;
    typedef logic [$clog2(ENTRIES_N+1)-1:0]     listsize_t;

    typedef struct packed {
        logic [ENTRIES_N-1:0]    vld;
        key_t [ENTRIES_N-1:0]    key;
        volume_t [ENTRIES_N-1:0] volume;
        listsize_t               listsize;
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_DEL = 2'd1,
        OP_REP = 2'd2,
        OP_CLR = 2'd3
    } op_e;
endpackage

module v_pipe_update #(
    // Must match v_pkg::ENTRIES_N, which sizes the state_t vectors.
    parameter int ENTRIES_N = v_pkg::ENTRIES_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_upd_vld,
    input  logic [1:0]       i_upd_op,
    input  v_pkg::id_t       i_upd_prod_id,
    input  v_pkg::level_t    i_upd_level,
    input  v_pkg::key_t      i_upd_key,
    input  v_pkg::volume_t   i_upd_size,
    output logic             o_upd_rdy,
    output logic             o_upd_vld_r,
    output logic             o_upd_error,
    output logic             o_state_ren,
    output v_pkg::addr_t     o_state_raddr,
    input  v_pkg::state_t    i_state_rdata,
    output logic             o_state_wen,
    output v_pkg::addr_t     o_state_waddr,
    output v_pkg::state_t    o_state_wdata,
    output logic             o_s1_upd_vld_r,
    output v_pkg::id_t       o_s1_upd_prod_id_r,
    output logic             o_s2_upd_vld_r,
    output v_pkg::id_t       o_s2_upd_prod_id_r,
    output logic             o_s3_upd_vld_r,
    output v_pkg::id_t       o_s3_upd_prod_id_r,
    output logic             o_s4_upd_vld_r,
    output v_pkg::id_t       o_s4_upd_prod_id_r
);
    localparam int            LVL_IW  = (ENTRIES_N > 1) ? $clog2(ENTRIES_N) : 1;
    localparam v_pkg::level_t LVL_LIM = v_pkg::level_t'(ENTRIES_N);

    logic            accept;

    logic            s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;
    v_pkg::op_e      s1_op_q, s2_op_q;
    v_pkg::id_t      s1_id_q, s2_id_q, s3_id_q, s4_id_q;
    v_pkg::level_t   s1_level_q, s2_level_q;
    v_pkg::key_t     s1_key_q, s2_key_q;
    v_pkg::volume_t  s1_size_q, s2_size_q;
    v_pkg::state_t   s1_st;
    v_pkg::state_t   s2_st_q, s2_st_d, s3_st_q;
    logic            s2_err, s3_err_q, s4_err_q;
    logic            s2_in_range;
    logic [LVL_IW-1:0] s2_idx;

`ifdef V_PIPE_UPDATE_FWD_EN
    v_pkg::state_t   s4_st_q;

    assign o_upd_rdy = !rst;

    // Youngest older command with the same ID wins; its next state is valid
    // even when it errored, because an error leaves the state untouched.
    // S4 is included because the read for S1 overlapped that command's write.
    always_comb begin
        s1_st = i_state_rdata;
        if (s2_vld_q && (s2_id_q == s1_id_q)) begin
            s1_st = s2_st_d;
        end else if (s3_vld_q && (s3_id_q == s1_id_q)) begin
            s1_st = s3_st_q;
        end else if (s4_vld_q && (s4_id_q == s1_id_q)) begin
            s1_st = s4_st_q;
        end
    end
`else
    // Stall while an older same-ID command has not yet written; S4 is exempt
    // because its write landed at the end of S3.
    always_comb begin
        o_upd_rdy = 1'b1;
        if ((s1_vld_q && (s1_id_q == i_upd_prod_id)) ||
            (s2_vld_q && (s2_id_q == i_upd_prod_id)) ||
            (s3_vld_q && (s3_id_q == i_upd_prod_id))) begin
            o_upd_rdy = 1'b0;
        end
    end

    always_comb begin
        s1_st = i_state_rdata;
    end
`endif

    assign accept        = i_upd_vld & o_upd_rdy & !rst;
    assign o_state_ren   = accept;
    assign o_state_raddr = i_upd_prod_id;

    // S2: modify the captured list state.
    assign s2_in_range = (s2_level_q < LVL_LIM);
    assign s2_idx      = s2_level_q[LVL_IW-1:0];

    always_comb begin
        s2_st_d = s2_st_q;
        s2_err  = 1'b0;
        case (s2_op_q)
            v_pkg::OP_ADD: begin
                if (!s2_in_range || s2_st_q.vld[s2_idx]) begin
                    s2_err = 1'b1;
                end else begin
                    s2_st_d.vld[s2_idx]    = 1'b1;
                    s2_st_d.key[s2_idx]    = s2_key_q;
                    s2_st_d.volume[s2_idx] = s2_size_q;
                    s2_st_d.listsize       = s2_st_q.listsize + v_pkg::listsize_t'(1);
                end
            end
            v_pkg::OP_DEL: begin
                if (!s2_in_range || !s2_st_q.vld[s2_idx]) begin
                    s2_err = 1'b1;
                end else begin
                    s2_st_d.vld[s2_idx] = 1'b0;
                    s2_st_d.listsize    = s2_st_q.listsize - v_pkg::listsize_t'(1);
                end
            end
            v_pkg::OP_REP: begin
                if (!s2_in_range || !s2_st_q.vld[s2_idx]) begin
                    s2_err = 1'b1;
                end else begin
                    s2_st_d.key[s2_idx]    = s2_key_q;
                    s2_st_d.volume[s2_idx] = s2_size_q;
                end
            end
            default: begin
                // CLR keeps key/volume contents; only validity and count drop.
                s2_st_d.vld      = '0;
                s2_st_d.listsize = '0;
            end
        endcase
    end

    // Stage occupancy; reset drops every in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
            s4_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            s4_vld_q <= s3_vld_q;
        end
    end

    // Payload registers are qualified by the stage valids and need no reset.
    always_ff @(posedge clk) begin
        s1_op_q    <= v_pkg::op_e'(i_upd_op);
        s1_id_q    <= i_upd_prod_id;
        s1_level_q <= i_upd_level;
        s1_key_q   <= i_upd_key;
        s1_size_q  <= i_upd_size;

        s2_op_q    <= s1_op_q;
        s2_id_q    <= s1_id_q;
        s2_level_q <= s1_level_q;
        s2_key_q   <= s1_key_q;
        s2_size_q  <= s1_size_q;
        s2_st_q    <= s1_st;

        s3_id_q    <= s2_id_q;
        s3_err_q   <= s2_err;
        s3_st_q    <= s2_st_d;

        s4_id_q    <= s3_id_q;
        s4_err_q   <= s3_err_q;
`ifdef V_PIPE_UPDATE_FWD_EN
        s4_st_q    <= s3_st_q;
`endif
    end

    // Gated by rst so a command caught in S3/S4 when reset rises never lands.
    assign o_state_wen   = s3_vld_q & !s3_err_q & !rst;
    assign o_state_waddr = s3_id_q;
    assign o_state_wdata = s3_st_q;

    assign o_upd_vld_r   = s4_vld_q & !rst;
    assign o_upd_error   = s4_vld_q & s4_err_q & !rst;

    assign o_s1_upd_vld_r     = s1_vld_q;
    assign o_s1_upd_prod_id_r = s1_id_q;
    assign o_s2_upd_vld_r     = s2_vld_q;
    assign o_s2_upd_prod_id_r = s2_id_q;
    assign o_s3_upd_vld_r     = s3_vld_q;
    assign o_s3_upd_prod_id_r = s3_id_q;
    assign o_s4_upd_vld_r     = s4_vld_q;
    assign o_s4_upd_prod_id_r = s4_id_q;

endmodule

// File: tb/tb_v_pipe_update.sv
// Testbench for v_pipe_update: state-table memory model, cycle monitor with a
// list-level reference model and expected queues, plus directed scenario tasks.
module tb_v_pipe_update;
  import v_pkg::*;

`ifdef V_PIPE_UPDATE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int NL = v_pkg::ENTRIES_N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic       i_upd_vld = 1'b0;
  logic [1:0] i_upd_op = 2'd0;
  id_t        i_upd_prod_id = '0;
  level_t     i_upd_level = '0;
  key_t       i_upd_key = '0;
  volume_t    i_upd_size = '0;
  logic       o_upd_rdy, o_upd_vld_r, o_upd_error;
  logic       o_state_ren, o_state_wen;
  addr_t      o_state_raddr, o_state_waddr;
  state_t     i_state_rdata = '0;
  state_t     o_state_wdata;
  logic       o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r;
  id_t        o_s1_upd_prod_id_r, o_s2_upd_prod_id_r, o_s3_upd_prod_id_r, o_s4_upd_prod_id_r;

  v_pipe_update dut (
    .clk(clk), .rst(rst),
    .i_upd_vld(i_upd_vld), .i_upd_op(i_upd_op), .i_upd_prod_id(i_upd_prod_id),
    .i_upd_level(i_upd_level), .i_upd_key(i_upd_key), .i_upd_size(i_upd_size),
    .o_upd_rdy(o_upd_rdy), .o_upd_vld_r(o_upd_vld_r), .o_upd_error(o_upd_error),
    .o_state_ren(o_state_ren), .o_state_raddr(o_state_raddr), .i_state_rdata(i_state_rdata),
    .o_state_wen(o_state_wen), .o_state_waddr(o_state_waddr), .o_state_wdata(o_state_wdata),
    .o_s1_upd_vld_r(o_s1_upd_vld_r), .o_s1_upd_prod_id_r(o_s1_upd_prod_id_r),
    .o_s2_upd_vld_r(o_s2_upd_vld_r), .o_s2_upd_prod_id_r(o_s2_upd_prod_id_r),
    .o_s3_upd_vld_r(o_s3_upd_vld_r), .o_s3_upd_prod_id_r(o_s3_upd_prod_id_r),
    .o_s4_upd_vld_r(o_s4_upd_vld_r), .o_s4_upd_prod_id_r(o_s4_upd_prod_id_r)
  );

  logic [4:1] s_vld;
  id_t        s_id [1:4];
  assign s_vld = {o_s4_upd_vld_r, o_s3_upd_vld_r, o_s2_upd_vld_r, o_s1_upd_vld_r};
  assign s_id[1] = o_s1_upd_prod_id_r;
  assign s_id[2] = o_s2_upd_prod_id_r;
  assign s_id[3] = o_s3_upd_prod_id_r;
  assign s_id[4] = o_s4_upd_prod_id_r;

  // ---------------- state table (1-cycle read, not reset) ----------------
  state_t mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (o_state_wen) mem[o_state_waddr] <= o_state_wdata;
    if (o_state_ren) i_state_rdata <= mem[o_state_raddr];
  end

  // ---------------- reference model ----------------
  int n_cmp = 0;
  int n_mis = 0;

  bit          m_vld [16][NL];
  int unsigned m_key [16][NL];
  int unsigned m_vol [16][NL];
  int          m_cnt [16];

  task automatic model_apply(input int op, input int id, input int lvl,
                             input int unsigned key, input int unsigned sz, output bit err);
    err = 1'b0;
    if (op == 3) begin
      for (int l = 0; l < NL; l++) m_vld[id][l] = 1'b0;
      m_cnt[id] = 0;
    end else if (lvl >= NL) begin
      err = 1'b1;
    end else if (op == 0) begin
      if (m_vld[id][lvl]) err = 1'b1;
      else begin
        m_vld[id][lvl] = 1'b1; m_key[id][lvl] = key; m_vol[id][lvl] = sz; m_cnt[id]++;
      end
    end else if (op == 1) begin
      if (!m_vld[id][lvl]) err = 1'b1;
      else begin m_vld[id][lvl] = 1'b0; m_cnt[id]--; end
    end else begin
      if (!m_vld[id][lvl]) err = 1'b1;
      else begin m_key[id][lvl] = key; m_vol[id][lvl] = sz; end
    end
  endtask

  function automatic state_t model_state(input int id);
    state_t s;
    s = '0;
    for (int l = 0; l < NL; l++) begin
      s.vld[l]    = m_vld[id][l];
      s.key[l]    = key_t'(m_key[id][l]);
      s.volume[l] = volume_t'(m_vol[id][l]);
    end
    s.listsize = listsize_t'(m_cnt[id]);
    return s;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int     rsp_cyc_q[$];
  bit     rsp_err_q[$];
  int     wr_cyc_q[$];
  id_t    wr_id_q[$];
  state_t wr_dat_q[$];
  bit     h_vld [8];
  id_t    h_id  [8];

  always @(negedge clk) begin : mon
    int k;
    int hi;
    bit exp_rdy, acc, e_rsp, e_wr, err;
    k = cyc;
    if (rst) begin
      for (int i = 0; i < 8; i++) h_vld[i] = 1'b0;
      rsp_cyc_q.delete(); rsp_err_q.delete();
      wr_cyc_q.delete(); wr_id_q.delete(); wr_dat_q.delete();
      n_cmp++;
      if (o_state_ren !== 1'b0 || o_state_wen !== 1'b0 || o_upd_vld_r !== 1'b0 || o_upd_error !== 1'b0) begin
        n_mis++;
        $display("FAIL mon_reset_quiet cyc=%0d ren=%b wen=%b vld_r=%b err=%b need all 0",
                 k, o_state_ren, o_state_wen, o_upd_vld_r, o_upd_error);
      end
    end else begin
      // ready: stall only on a same-ID command accepted 1..3 cycles ago
      exp_rdy = 1'b1;
      if (!FWD) begin
        for (int d = 1; d <= 3; d++) begin
          hi = (k - d) & 7;
          if (h_vld[hi] && h_id[hi] == i_upd_prod_id) exp_rdy = 1'b0;
        end
      end
      n_cmp++;
      if (o_upd_rdy !== exp_rdy) begin
        n_mis++;
        $display("FAIL mon_rdy cyc=%0d got=%b exp=%b", k, o_upd_rdy, exp_rdy);
      end
      // stage occupancy: command accepted in cycle k-n sits in stage n
      for (int n = 1; n <= 4; n++) begin
        hi = (k - n) & 7;
        n_cmp++;
        if (s_vld[n] !== h_vld[hi] || (h_vld[hi] && s_id[n] !== h_id[hi])) begin
          n_mis++;
          $display("FAIL mon_stage%0d cyc=%0d got vld=%b id=%0d exp vld=%b id=%0d",
                   n, k, s_vld[n], s_id[n], h_vld[hi], h_id[hi]);
        end
      end
      // response at accept+4
      while (rsp_cyc_q.size() > 0 && rsp_cyc_q[0] < k) begin
        void'(rsp_cyc_q.pop_front()); void'(rsp_err_q.pop_front());
      end
      e_rsp = (rsp_cyc_q.size() > 0 && rsp_cyc_q[0] == k);
      n_cmp++;
      if (o_upd_vld_r !== e_rsp) begin
        n_mis++;
        $display("FAIL mon_rsp_vld cyc=%0d got=%b exp=%b", k, o_upd_vld_r, e_rsp);
      end
      if (e_rsp) begin
        void'(rsp_cyc_q.pop_front());
        err = rsp_err_q.pop_front();
        n_cmp++;
        if (o_upd_error !== err) begin
          n_mis++;
          $display("FAIL mon_rsp_err cyc=%0d got=%b exp=%b", k, o_upd_error, err);
        end
      end else begin
        n_cmp++;
        if (o_upd_error !== 1'b0) begin
          n_mis++;
          $display("FAIL mon_err_idle cyc=%0d got=%b exp=0", k, o_upd_error);
        end
      end
      // write at accept+3, only for non-errored commands
      while (wr_cyc_q.size() > 0 && wr_cyc_q[0] < k) begin
        void'(wr_cyc_q.pop_front()); void'(wr_id_q.pop_front()); void'(wr_dat_q.pop_front());
      end
      e_wr = (wr_cyc_q.size() > 0 && wr_cyc_q[0] == k);
      n_cmp++;
      if (o_state_wen !== e_wr) begin
        n_mis++;
        $display("FAIL mon_wen cyc=%0d got=%b exp=%b", k, o_state_wen, e_wr);
      end
      if (e_wr) begin
        n_cmp++;
        if (o_state_waddr !== wr_id_q[0] || o_state_wdata !== wr_dat_q[0]) begin
          n_mis++;
          $display("FAIL mon_wdata cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                   k, o_state_waddr, o_state_wdata, wr_id_q[0], wr_dat_q[0]);
        end
        void'(wr_cyc_q.pop_front()); void'(wr_id_q.pop_front()); void'(wr_dat_q.pop_front());
      end
      // acceptance and read request
      acc = i_upd_vld && o_upd_rdy;
      n_cmp++;
      if (o_state_ren !== acc || (acc && o_state_raddr !== i_upd_prod_id)) begin
        n_mis++;
        $display("FAIL mon_ren cyc=%0d got ren=%b addr=%0d exp ren=%b addr=%0d",
                 k, o_state_ren, o_state_raddr, acc, i_upd_prod_id);
      end
      if (acc) begin
        model_apply(int'(i_upd_op), int'(i_upd_prod_id), int'(i_upd_level),
                    int'(i_upd_key), int'(i_upd_size), err);
        rsp_cyc_q.push_back(k + 4);
        rsp_err_q.push_back(err);
        if (!err) begin
          wr_cyc_q.push_back(k + 3);
          wr_id_q.push_back(i_upd_prod_id);
          wr_dat_q.push_back(model_state(int'(i_upd_prod_id)));
        end
      end
      h_vld[k & 7] = acc;
      h_id[k & 7]  = i_upd_prod_id;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one command and holds it until accepted; returns accept cycle and stall count.
  task automatic issue(input int op, input int id, input int lvl, input int key, input int sz,
                       output int acc_cyc, output int stalls);
    i_upd_vld = 1'b1;
    i_upd_op = 2'(op);
    i_upd_prod_id = id_t'(id);
    i_upd_level = level_t'(lvl);
    i_upd_key = key_t'(key);
    i_upd_size = volume_t'(sz);
    stalls = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (o_upd_rdy === 1'b1) begin
        acc_cyc = cyc;
        break;
      end
      stalls++;
      if (stalls > 20) begin
        n_cmp++; n_mis++;
        $display("FAIL issue_timeout id=%0d got no ready in 20 cycles exp ready", id);
        break;
      end
    end
    @(posedge clk); #1;
    i_upd_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watches n cycles for a write to id and for a response.
  task automatic observe(input int id, input int n, output int wc, output state_t wd,
                         output int rc, output bit re);
    wc = -1; rc = -1; wd = '0; re = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (o_state_wen === 1'b1 && o_state_waddr === id_t'(id)) begin wc = cyc; wd = o_state_wdata; end
      if (o_upd_vld_r === 1'b1) begin rc = cyc; re = o_upd_error; end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    i_upd_vld = 1'b1;
    i_upd_prod_id = id_t'($urandom_range(0, 15));
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (o_state_ren !== 1'b0 || o_state_wen !== 1'b0 || o_upd_vld_r !== 1'b0) begin
        n_mis++;
        $display("FAIL reset_outputs got ren=%b wen=%b vld_r=%b exp 0 0 0", o_state_ren, o_state_wen, o_upd_vld_r);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    i_upd_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_upd_rdy !== 1'b1 || o_s1_upd_vld_r !== 1'b0 || o_s4_upd_vld_r !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_release got rdy=%b s1=%b s4=%b exp 1 0 0", o_upd_rdy, o_s1_upd_vld_r, o_s4_upd_vld_r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    int t, s, wc, rc; state_t wd; bit re;
    issue(0, 3, 2, 'h5, 'h10, t, s);
    observe(3, 6, wc, wd, rc, re);
    n_cmp++;
    if (wc !== t + 3 || wd.vld !== 4'b0100 || wd.listsize !== 3'd1 ||
        wd.key[2] !== 8'h05 || wd.volume[2] !== 16'h0010) begin
      n_mis++;
      $display("FAIL add_basic_write got cyc=%0d vld=%b ls=%0d key=%h vol=%h exp cyc=%0d vld=0100 ls=1 key=05 vol=0010",
               wc, wd.vld, wd.listsize, wd.key[2], wd.volume[2], t + 3);
    end
    n_cmp++;
    if (rc !== t + 4 || re !== 1'b0) begin
      n_mis++;
      $display("FAIL add_basic_rsp got cyc=%0d err=%b exp cyc=%0d err=0", rc, re, t + 4);
    end
  endtask

  task automatic test_add_dup();
    int t, s, wc, rc; state_t wd; bit re;
    issue(0, 3, 2, 'h6, 'h20, t, s);
    observe(3, 6, wc, wd, rc, re);
    n_cmp++;
    if (wc !== -1 || rc !== t + 4 || re !== 1'b1 || mem[3].listsize !== 3'd1) begin
      n_mis++;
      $display("FAIL add_dup got wcyc=%0d rcyc=%0d err=%b ls=%0d exp wcyc=-1 rcyc=%0d err=1 ls=1",
               wc, rc, re, mem[3].listsize, t + 4);
    end
  endtask

  task automatic test_del_invalid();
    int t, s, wc, rc; state_t wd; bit re;
    issue(1, 3, 1, 0, 0, t, s);
    observe(3, 6, wc, wd, rc, re);
    n_cmp++;
    if (wc !== -1 || rc !== t + 4 || re !== 1'b1) begin
      n_mis++;
      $display("FAIL del_invalid got wcyc=%0d rcyc=%0d err=%b exp wcyc=-1 rcyc=%0d err=1", wc, rc, re, t + 4);
    end
  endtask

  task automatic test_level_range();
    int t, s, wc, rc; state_t wd; bit re;
    issue(0, 5, NL, 'h11, 'h22, t, s);
    observe(5, 6, wc, wd, rc, re);
    n_cmp++;
    if (wc !== -1 || re !== 1'b1) begin
      n_mis++;
      $display("FAIL level_range got wcyc=%0d err=%b exp wcyc=-1 err=1", wc, re);
    end
    issue(2, 3, 2, 'h77, 'h1234, t, s);
    observe(3, 6, wc, wd, rc, re);
    n_cmp++;
    if (wc !== t + 3 || re !== 1'b0 || wd.key[2] !== 8'h77 || wd.volume[2] !== 16'h1234 || wd.listsize !== 3'd1) begin
      n_mis++;
      $display("FAIL rep_valid got wcyc=%0d err=%b key=%h vol=%h ls=%0d exp wcyc=%0d err=0 key=77 vol=1234 ls=1",
               wc, re, wd.key[2], wd.volume[2], wd.listsize, t + 3);
    end
  endtask

  task automatic test_back_to_back();
    int t1, s1, t2, s2;
    issue(0, 7, 0, 'h70, 'h700, t1, s1);
    issue(0, 7, 1, 'h71, 'h701, t2, s2);
    n_cmp++;
    if (s2 !== (FWD ? 0 : 3) || t2 - t1 !== (FWD ? 1 : 4)) begin
      n_mis++;
      $display("FAIL b2b_stall got stalls=%0d gap=%0d exp stalls=%0d gap=%0d",
               s2, t2 - t1, FWD ? 0 : 3, FWD ? 1 : 4);
    end
    idle(8);
    n_cmp++;
    if (mem[7].vld !== 4'b0011 || mem[7].listsize !== 3'd2) begin
      n_mis++;
      $display("FAIL b2b_final got vld=%b ls=%0d exp vld=0011 ls=2", mem[7].vld, mem[7].listsize);
    end
  endtask

  task automatic test_clr_inflight();
    int t1, s1, t2, s2;
    issue(0, 9, 1, 'h9, 'h99, t1, s1);
    issue(3, 7, 0, 0, 0, t2, s2);
    n_cmp++;
    if (t2 - t1 !== 1) begin
      n_mis++;
      $display("FAIL clr_no_stall got gap=%0d exp gap=1", t2 - t1);
    end
    idle(8);
    n_cmp++;
    if (mem[7].vld !== 4'b0000 || mem[7].listsize !== 3'd0 || mem[7].key[1] !== 8'h71) begin
      n_mis++;
      $display("FAIL clr_id7 got vld=%b ls=%0d key1=%h exp vld=0000 ls=0 key1=71",
               mem[7].vld, mem[7].listsize, mem[7].key[1]);
    end
    n_cmp++;
    if (mem[9].vld !== 4'b0010 || mem[9].listsize !== 3'd1 || mem[9].key[1] !== 8'h09) begin
      n_mis++;
      $display("FAIL clr_id9 got vld=%b ls=%0d key1=%h exp vld=0010 ls=1 key1=09",
               mem[9].vld, mem[9].listsize, mem[9].key[1]);
    end
  endtask

  task automatic test_random();
    int t, s, r, op;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      issue(op, $urandom_range(0, 5), $urandom_range(0, NL), $urandom_range(0, 255),
            $urandom_range(0, 65535), t, s);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(8);
    for (int id = 0; id < 16; id++) begin
      n_cmp++;
      if (mem[id] !== model_state(id)) begin
        n_mis++;
        $display("FAIL table_id%0d got=%h exp=%h", id, mem[id], model_state(id));
      end
    end
  endtask

  initial begin
    for (int id = 0; id < 16; id++) begin
      m_cnt[id] = 0;
      for (int l = 0; l < NL; l++) begin
        m_vld[id][l] = 1'b0; m_key[id][l] = 0; m_vol[id][l] = 0;
      end
    end
    test_reset();
    test_add_basic();
    test_add_dup();
    test_del_invalid();
    test_level_range();
    test_back_to_back();
    test_clr_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
